instruction_decode_stage: RTL and testbench
===========================================

INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001: Parameter CHECK_FUNCT, default 1; when 1, reserved funct3/funct7 encodings SHALL raise out_illegal; when 0, only opcode is checked.
REQ-002: clk  input  1  sole clock; all state on rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-low; asserting low clears state immediately, release is synchronised externally.
REQ-004: in_valid  input  1  upstream offers in_instr/in_pc.
REQ-005: in_ready  output  1  stage can accept this cycle.
REQ-006: in_instr  input  32  RV32I instruction word; in_pc  input  32  its address.
REQ-007: flush  input  1  discard held and incoming instruction.
REQ-008: rd_addr0, rd_addr1  output  5  rs1/rs2 indices to the register-file read ports.
REQ-009: out_valid  output  1  decoded instruction present; out_ready  input  1  downstream accepts.
REQ-010: out_pc  output  32;  out_rd  output  5;  out_imm  output  32  sign-extended immediate.
REQ-011: out_format  output  instr_format_t;  out_opcode  output  7;  out_funct3  output  3;  out_funct7_5  output  1.
REQ-012: out_reg_write  output  1  writeback enable;  out_illegal  output  1  undecodable instruction.

Function
REQ-013: Single pipeline register; in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-014: Accept = in_valid && in_ready; on accept, out_* SHALL load decoded fields next edge and out_valid SHALL go 1.
REQ-015: out_valid && !out_ready SHALL hold every out_* stable (no change, no drop).
REQ-016: out_valid && out_ready && !in_valid SHALL clear out_valid next edge.
REQ-017: flush SHALL clear out_valid next edge and SHALL suppress any accept that cycle; flush has priority over all other events.
REQ-018: rd_addr0/rd_addr1 SHALL be combinational: from in_instr[19:15]/[24:20] when accept occurs, else from the held instruction, so register-file data (one-cycle read latency) aligns with out_valid.
REQ-019: rd_addr0 SHALL be 0 for U/J formats; rd_addr1 SHALL be 0 unless format is R, S or B.
REQ-020: Opcode map: 0110011 R, 0010011/0000011/1100111 I, 0100011 S, 1100011 B, 0110111/0010111 U, 1101111 J; any other opcode SHALL give format NONE and out_illegal=1.
REQ-021: Immediates per RV32I spec, bit 31 sign-extended; B/J bit 0 = 0; U low 12 bits = 0; R/NONE imm = 0.
REQ-022: With CHECK_FUNCT=1: R with funct7 not 0000000/0100000, 0100000 with funct3 not 000/101, SLLI/SRLI/SRAI with illegal funct7, B funct3 010/011, load funct3 011/110/111, store funct3 >010, JALR funct3 != 000 SHALL be illegal.
REQ-023: out_reg_write SHALL be 1 only for R, I, U, J formats with rd != 0 and !out_illegal; S/B/NONE SHALL give 0.
REQ-024: out_rd SHALL be 0 whenever out_reg_write=0.

Reset
REQ-025: During rst low: out_valid=0, all other out_* registers=0, rd_addr0/rd_addr1=0; in_ready=1 immediately after release.
REQ-026: Reset mid-stall SHALL drop the held instruction without emitting it.

Structure
REQ-027: Package rv32i_pkg SHALL hold opcode constants, funct3/funct7 constants, and enum instr_format_t {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}.
REQ-028: Immediate extraction SHALL live in combinational sub-module immediate_generator (inputs instr, format; output 32-bit imm).

Verification
REQ-029: Accept 0xFFF08293 (ADDI x5,x1,-1) -> next cycle out_valid=1, rd_addr0=1, out_rd=5, out_imm=0xFFFFFFFF, FMT_I, reg_write=1.
REQ-030: 0x002081B3 (ADD) then 0x0020A423 (SW x2,8(x1)) back-to-back, out_ready=1 -> ADD: rd_addr0=1, rd_addr1=2, out_rd=3; SW: out_imm=8, reg_write=0, out_rd=0.
REQ-031: 0x123453B7 (LUI x7) with out_ready=0 for 3 cycles -> out_imm=0x12345000 held, in_ready=0, rd_addr0=0 stable throughout.
REQ-032: 0x00000013 (NOP) -> reg_write=0; 0xFFFFFFFF -> out_illegal=1, FMT_NONE, reg_write=0.
REQ-033: flush asserted same cycle as in_valid with stalled output -> out_valid=0 next cycle, neither instruction emitted.
REQ-034: rst low while out_valid=1 and stalled -> out_valid=0 without a clock edge; after release, first accepted instruction decodes correctly.

Source files
------------

// File: rtl/rv32i_pkg.sv
// RV32I decode constants, instruction-format enum and opcode-to-format lookup.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rv32i_pkg;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } instr_format_t;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct3 values that need special checking
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_SW      = 3'b010;

    // funct7 values
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic instr_format_t opcode_format(input logic [6:0] opcode);
        instr_format_t fmt;
        case (opcode)
            OPC_OP:                        fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                     fmt = FMT_S;
            OPC_BRANCH:                    fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
            OPC_JAL:                       fmt = FMT_J;
            default:                       fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/immediate_generator.sv
// Extracts the sign-extended RV32I immediate for a given instruction format.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: instr[31:7] instruction bits above the opcode, format decoded format,
//        imm 32-bit immediate (zero for R/NONE).
module immediate_generator
    import rv32i_pkg::*;
(
    input  logic [31:7]   instr,  // opcode bits not needed: format is already decoded
    input  instr_format_t format,
    output logic [31:0]   imm
);

    always_comb begin
        imm = 32'd0;
        case (format)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'd0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: one pipeline register holding decoded fields of the accepted instruction.
// Latency: 1 cycle from accept to out_valid; rd_addr0/1 are combinational for 1-cycle regfile reads.
// Backpressure: valid/ready; in_ready = (!out_valid || out_ready) && !flush, outputs held while stalled.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_instr/in_pc upstream; flush;
//        rd_addr0/rd_addr1 regfile read indices; out_valid/out_ready and decoded out_* downstream.
module instruction_decode_stage
    import rv32i_pkg::*;
#(
    parameter bit CHECK_FUNCT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc,
    input  logic          flush,
    output logic [4:0]    rd_addr0,
    output logic [4:0]    rd_addr1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [4:0]    out_rd,
    output logic [31:0]   out_imm,
    output instr_format_t out_format,
    output logic [6:0]    out_opcode,
    output logic [2:0]    out_funct3,
    output logic          out_funct7_5,
    output logic          out_reg_write,
    output logic          out_illegal
);

    logic          r_valid;
    logic [31:0]   r_pc;
    logic [4:0]    r_rd;
    logic [31:0]   r_imm;
    instr_format_t r_format;
    logic [6:0]    r_opcode;
    logic [2:0]    r_funct3;
    logic          r_funct7_5;
    logic          r_reg_write;
    logic          r_illegal;
    logic [4:0]    r_rs1;
    logic [4:0]    r_rs2;

    logic [6:0]    w_opcode;
    logic [2:0]    w_funct3;
    logic [6:0]    w_funct7;
    logic [4:0]    w_rd;
    instr_format_t w_fmt;
    logic          w_funct_bad;
    logic          w_illegal;
    logic          w_reg_write;
    logic [31:0]   w_imm;
    logic          w_accept;
    logic [4:0]    w_sel_rs1;
    logic [4:0]    w_sel_rs2;
    instr_format_t w_sel_fmt;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_rd     = in_instr[11:7];
    assign w_fmt    = opcode_format(w_opcode);

    // Reserved funct encodings within otherwise valid opcodes
    always_comb begin
        w_funct_bad = 1'b0;
        case (w_opcode)
            OPC_OP: w_funct_bad = !(w_funct7 == F7_ZERO || w_funct7 == F7_ALT) ||
                                  (w_funct7 == F7_ALT && !(w_funct3 == F3_ADD_SUB || w_funct3 == F3_SRL_SRA));
            OPC_OP_IMM: begin
                // Only the shift-immediates use the funct7 field
                if (w_funct3 == F3_SLL)
                    w_funct_bad = (w_funct7 != F7_ZERO);
                else if (w_funct3 == F3_SRL_SRA)
                    w_funct_bad = !(w_funct7 == F7_ZERO || w_funct7 == F7_ALT);
            end
            OPC_BRANCH: w_funct_bad = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            OPC_LOAD:   w_funct_bad = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
            OPC_STORE:  w_funct_bad = (w_funct3 > F3_SW);
            OPC_JALR:   w_funct_bad = (w_funct3 != F3_JALR);
            default:    w_funct_bad = 1'b0;
        endcase
    end

    assign w_illegal   = (w_fmt == FMT_NONE) || (CHECK_FUNCT && w_funct_bad);
    assign w_reg_write = (w_fmt == FMT_R || w_fmt == FMT_I || w_fmt == FMT_U || w_fmt == FMT_J) &&
                         (w_rd != 5'd0) && !w_illegal;

    immediate_generator u_immgen (
        .instr  (in_instr[31:7]),
        .format (w_fmt),
        .imm    (w_imm)
    );

    assign in_ready = (!r_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    // Read indices follow the instruction that will be in the register next cycle,
    // so register-file data lines up with out_valid.
    assign w_sel_rs1 = w_accept ? in_instr[19:15] : r_rs1;
    assign w_sel_rs2 = w_accept ? in_instr[24:20] : r_rs2;
    assign w_sel_fmt = w_accept ? w_fmt : r_format;

    assign rd_addr0 = (!rst || w_sel_fmt == FMT_U || w_sel_fmt == FMT_J) ? 5'd0 : w_sel_rs1;
    assign rd_addr1 = (rst && (w_sel_fmt == FMT_R || w_sel_fmt == FMT_S || w_sel_fmt == FMT_B))
                      ? w_sel_rs2 : 5'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_pc        <= 32'd0;
            r_rd        <= 5'd0;
            r_imm       <= 32'd0;
            r_format    <= FMT_NONE;
            r_opcode    <= 7'd0;
            r_funct3    <= 3'd0;
            r_funct7_5  <= 1'b0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_pc        <= in_pc;
            r_rd        <= w_reg_write ? w_rd : 5'd0;
            r_imm       <= w_imm;
            r_format    <= w_fmt;
            r_opcode    <= w_opcode;
            r_funct3    <= w_funct3;
            r_funct7_5  <= in_instr[30];
            r_reg_write <= w_reg_write;
            r_illegal   <= w_illegal;
            r_rs1       <= in_instr[19:15];
            r_rs2       <= in_instr[24:20];
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_pc;
    assign out_rd        = r_rd;
    assign out_imm       = r_imm;
    assign out_format    = r_format;
    assign out_opcode    = r_opcode;
    assign out_funct3    = r_funct3;
    assign out_funct7_5  = r_funct7_5;
    assign out_reg_write = r_reg_write;
    assign out_illegal   = r_illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for instruction_decode_stage: expected decodes are queued on accept and
// compared against the output register every cycle it is valid.
// Inputs change 1-2 time units after posedge; all sampling happens on negedge.
module tb_instruction_decode_stage;
    import rv32i_pkg::*;

    typedef struct {
        logic [31:0]   pc;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic [31:0]   imm;
        instr_format_t fmt;
        logic [6:0]    op;
        logic [2:0]    f3;
        logic          f75;
        logic          rw;
        logic          ill;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [31:0]   in_pc;
    logic          flush;
    logic [4:0]    rd_addr0;
    logic [4:0]    rd_addr1;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [4:0]    out_rd;
    logic [31:0]   out_imm;
    instr_format_t out_format;
    logic [6:0]    out_opcode;
    logic [2:0]    out_funct3;
    logic          out_funct7_5;
    logic          out_reg_write;
    logic          out_illegal;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t cur_exp;
    exp_t held;
    logic exp_vld = 1'b0;
    logic acc_now = 1'b0;

    always #5 clk = ~clk;

    instruction_decode_stage #(.CHECK_FUNCT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
        .out_imm(out_imm), .out_format(out_format), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7_5(out_funct7_5),
        .out_reg_write(out_reg_write), .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm, input instr_format_t fmt,
                                input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                input logic rw, input logic ill);
        exp_t e;
        e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm; e.fmt = fmt;
        e.op = op; e.f3 = f3; e.f75 = f75; e.rw = rw; e.ill = ill;
        return e;
    endfunction

    // Monitor / scoreboard: tracks expected out_valid and the held read indices.
    initial begin
        logic exp_rdy;
        logic acc;
        held = mk(0, 0, 0, 0, 0, FMT_NONE, 0, 0, 0, 0, 0);
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_rd_addr0", rd_addr0, 0);
                chk("rst_rd_addr1", rd_addr1, 0);
                chk("rst_out_imm", out_imm, 0);
                chk("rst_out_rd", out_rd, 0);
                acc_now = 1'b0;
            end else begin
                exp_rdy = (!exp_vld || out_ready) && !flush;
                acc = in_valid && exp_rdy;
                chk("in_ready", in_ready, exp_rdy);
                chk("out_valid", out_valid, exp_vld);
                if (exp_vld) begin
                    if (q.size() == 0) begin
                        chk("scoreboard_underflow", 1, 0);
                    end else begin
                        chk("out_pc", out_pc, q[0].pc);
                        chk("out_rd", out_rd, q[0].rd);
                        chk("out_imm", out_imm, q[0].imm);
                        chk("out_format", 32'(out_format), 32'(q[0].fmt));
                        chk("out_opcode", out_opcode, q[0].op);
                        chk("out_funct3", out_funct3, q[0].f3);
                        chk("out_funct7_5", out_funct7_5, q[0].f75);
                        chk("out_reg_write", out_reg_write, q[0].rw);
                        chk("out_illegal", out_illegal, q[0].ill);
                    end
                end
                if (acc) begin
                    chk("rd_addr0_acc", rd_addr0, cur_exp.rs1);
                    chk("rd_addr1_acc", rd_addr1, cur_exp.rs2);
                end else begin
                    chk("rd_addr0_held", rd_addr0, held.rs1);
                    chk("rd_addr1_held", rd_addr1, held.rs2);
                end
                if (flush) begin
                    if (exp_vld && q.size() > 0) void'(q.pop_front());
                    exp_vld = 1'b0;
                end else begin
                    if (exp_vld && out_ready) begin
                        if (q.size() > 0) void'(q.pop_front());
                        exp_vld = 1'b0;
                    end
                    if (acc) begin
                        q.push_back(cur_exp);
                        held = cur_exp;
                        exp_vld = 1'b1;
                    end
                end
                acc_now = acc;
            end
        end
    end

    // Called at a posedge; returns at the posedge where the instruction was taken.
    task automatic issue(input logic [31:0] instr, input exp_t e);
        bit done;
        done = 0;
        #1;
        in_instr = instr;
        in_pc    = e.pc;
        cur_exp  = e;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (acc_now) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        #1;
        in_valid = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);

        // Basic decode, back-to-back with a ready consumer
        issue(32'hFFF08293, mk(32'h100, 1, 0, 5, 32'hFFFFFFFF, FMT_I, 7'h13, 3'd0, 1'b1, 1'b1, 1'b0));
        issue(32'h002081B3, mk(32'h104, 1, 2, 3, 32'h0, FMT_R, 7'h33, 3'd0, 1'b0, 1'b1, 1'b0));
        issue(32'h0020A423, mk(32'h108, 1, 2, 0, 32'h8, FMT_S, 7'h23, 3'd2, 1'b0, 1'b0, 1'b0));
        idle();
        @(posedge clk);

        // LUI stalled for three cycles while the next instruction waits
        #1 out_ready = 1'b0;
        issue(32'h123453B7, mk(32'h10C, 0, 0, 7, 32'h12345000, FMT_U, 7'h37, 3'd5, 1'b0, 1'b1, 1'b0));
        fork
            issue(32'h00000013, mk(32'h110, 0, 0, 0, 32'h0, FMT_I, 7'h13, 3'd0, 1'b0, 1'b0, 1'b0));
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        issue(32'hFFFFFFFF, mk(32'h114, 31, 0, 0, 32'h0, FMT_NONE, 7'h7F, 3'd7, 1'b1, 1'b0, 1'b1));
        issue(32'h40001033, mk(32'h118, 0, 0, 0, 32'h0, FMT_R, 7'h33, 3'd1, 1'b1, 1'b0, 1'b1));
        issue(32'hFE208EE3, mk(32'h11C, 1, 2, 0, 32'hFFFFFFFC, FMT_B, 7'h63, 3'd0, 1'b1, 1'b0, 1'b0));
        issue(32'h008000EF, mk(32'h120, 0, 0, 1, 32'h8, FMT_J, 7'h6F, 3'd0, 1'b0, 1'b1, 1'b0));
        issue(32'h0000E003, mk(32'h124, 1, 0, 0, 32'h0, FMT_I, 7'h03, 3'd6, 1'b0, 1'b0, 1'b1));
        issue(32'h4030D093, mk(32'h128, 1, 0, 1, 32'h403, FMT_I, 7'h13, 3'd5, 1'b1, 1'b1, 1'b0));
        idle();
        @(posedge clk);

        // Flush with a stalled output and a new instruction offered the same cycle
        #1 out_ready = 1'b0;
        issue(32'h002081B3, mk(32'h200, 1, 2, 3, 32'h0, FMT_R, 7'h33, 3'd0, 1'b0, 1'b1, 1'b0));
        #1;
        in_instr = 32'h0020A423;
        in_pc    = 32'h204;
        cur_exp  = mk(32'h204, 1, 2, 0, 32'h8, FMT_S, 7'h23, 3'd2, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);

        // Asynchronous reset while an instruction is held
        #1 out_ready = 1'b0;
        issue(32'h002081B3, mk(32'h300, 1, 2, 3, 32'h0, FMT_R, 7'h33, 3'd0, 1'b0, 1'b1, 1'b0));
        idle();
        #1 rst = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_pc", out_pc, 0);
        q.delete();
        exp_vld = 1'b0;
        held = mk(0, 0, 0, 0, 0, FMT_NONE, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        #1 chk("in_ready_after_release", in_ready, 1);
        @(posedge clk);
        issue(32'hFFF08293, mk(32'h304, 1, 0, 5, 32'hFFFFFFFF, FMT_I, 7'h13, 3'd0, 1'b1, 1'b1, 1'b0));
        idle();
        repeat (3) @(posedge clk);

        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
